// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_pkg
// Description : Shared constants for the MIPS multiply/divide unit.
//               - Operation encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
//               - FSM state codes: MD_IDLE, MD_RUN, MD_DONE.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    // Operation encodings, as driven on the op port by control
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer state codes
    localparam logic [1:0] MD_IDLE  = 2'b00;
    localparam logic [1:0] MD_RUN   = 2'b01;
    localparam logic [1:0] MD_DONE  = 2'b10;

endpackage : mips_muldiv_pkg
`default_nettype wire

// File: rtl/mips_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: shift-add. {acc, q} holds partial product and the
//                 not-yet-consumed multiplier bits; q[0] selects whether the
//                 multiplicand is added before the pair shifts right.
//               Divide: restoring subtract. {acc, q} shifts left, the divisor
//                 is trial-subtracted from the upper half and the quotient
//                 bit enters at q[0].
// Ports       : acc_in   [WIDTH-1:0] in  - accumulator (upper half / remainder)
//               q_in     [WIDTH-1:0] in  - multiplier / dividend-quotient bits
//               operand  [WIDTH-1:0] in  - multiplicand / divisor magnitude
//               div_mode             in  - 1 = divide step, 0 = multiply step
//               acc_out  [WIDTH-1:0] out - next accumulator
//               q_out    [WIDTH-1:0] out - next product / quotient bits
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    always_comb begin
        // Multiply: carry out of the add is kept so the right shift loses nothing
        w_sum       = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: partial remainder < divisor, so the shifted value fits WIDTH+1
        // bits and a set MSB of the difference means the subtract underflowed
        w_rem_shift = {acc_in, q_in[WIDTH-1]};
        w_diff      = w_rem_shift - {1'b0, operand};
        w_borrow    = w_diff[WIDTH];

        if (div_mode) begin
            acc_out = w_borrow ? w_rem_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], ~w_borrow};
        end else begin
            acc_out = w_sum[WIDTH:1];
            q_out   = {w_sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv
// Description : Iterative multiply/divide unit beside the execute-stage ALU.
//               Owns HI/LO. One datapath iteration per cycle, WIDTH cycles
//               per operation; signed ops run on magnitudes and are sign-fixed
//               on the completing edge.
// Ports       : clk, reset (async, active-high)
//               start, op[1:0], a, b    - launch MULT/MULTU/DIV/DIVU
//               mthi, mtlo              - write a into HI / LO when idle
//               hi, lo                  - HI/LO registers
//               busy                    - operation in flight
//               done                    - one-cycle pulse, HI/LO just updated
// Config      : MULDIV_FAST_MULT_EN - when defined, MULT/MULTU complete on the
//               edge after start without asserting busy; divides unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Registered state
    logic [1:0]       state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
    logic             div0_q,    div0_d;      // divisor was zero
    logic [CNT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] mq_q,      mq_d;        // multiplier / dividend-quotient
    logic [WIDTH-1:0] opnd_q,    opnd_d;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;

    // Combinational helpers
    logic             w_busy;
    logic             w_accept;
    logic             w_in_signed;
    logic             w_in_div;
    logic             w_in_mul;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_run_div;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_mq_nx;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    assign w_run_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc_in   (acc_q),
        .q_in     (mq_q),
        .operand  (opnd_q),
        .div_mode (w_run_div),
        .acc_out  (w_acc_nx),
        .q_out    (w_mq_nx)
    );

    always_comb begin
        w_busy      = (state_q == MD_RUN);
        w_accept    = start && !w_busy;
        w_in_signed = (op == MD_MULT) || (op == MD_DIV);
        w_in_div    = (op == MD_DIV)  || (op == MD_DIVU);
        w_in_mul    = (op == MD_MULT) || (op == MD_MULTU);
        w_a_neg     = w_in_signed && a[WIDTH-1];
        w_b_neg     = w_in_signed && b[WIDTH-1];
        w_abs_a     = w_a_neg ? -a : a;
        w_abs_b     = w_b_neg ? -b : b;

        // Sign fix-up of the final iteration's output
        w_prod_mag  = {w_acc_nx, w_mq_nx};
        w_prod      = neg_res_q ? -w_prod_mag : w_prod_mag;
        // Divide by zero forces an all-ones quotient; the remainder path
        // already yields the dividend because every trial subtract succeeds
        w_quot      = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -w_mq_nx : w_mq_nx);
        w_rem       = neg_rem_q ? -w_acc_nx : w_acc_nx;

`ifdef MULDIV_FAST_MULT_EN
        w_ext_a     = w_in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        w_ext_b     = w_in_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        w_fast_prod = w_ext_a * w_ext_b;
`endif

        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // Moves to HI/LO; a result written later in this block takes priority
        if (!w_busy) begin
            if (mthi) hi_d = a;
            if (mtlo) lo_d = a;
        end

        case (state_q)
            MD_RUN: begin
                acc_d   = w_acc_nx;
                mq_d    = w_mq_nx;
                count_d = count_q + 1'b1;
                if (count_q == LAST_CNT) begin
                    state_d = MD_DONE;
                    if (w_run_div) begin
                        hi_d = w_rem;
                        lo_d = w_quot;
                    end else begin
                        hi_d = w_prod[2*WIDTH-1:WIDTH];
                        lo_d = w_prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a new op; DONE otherwise falls to IDLE
                state_d = MD_IDLE;
                if (w_accept) begin
`ifdef MULDIV_FAST_MULT_EN
                    if (w_in_mul) begin
                        state_d = MD_DONE;
                        hi_d    = w_fast_prod[2*WIDTH-1:WIDTH];
                        lo_d    = w_fast_prod[WIDTH-1:0];
                    end else begin
`else
                    begin
`endif
                        state_d   = MD_RUN;
                        op_d      = op;
                        neg_res_d = w_a_neg ^ w_b_neg;
                        neg_rem_d = w_a_neg;
                        div0_d    = w_in_div && (b == {WIDTH{1'b0}});
                        count_d   = {CNT_W{1'b0}};
                        acc_d     = {WIDTH{1'b0}};
                        // Multiply tests multiplier bits from q; divide shifts dividend out of q
                        mq_d      = w_in_mul ? w_abs_b : w_abs_a;
                        opnd_d    = w_in_mul ? w_abs_a : w_abs_b;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= 2'b00;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            mq_q      <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = w_busy;
    assign done = (state_q == MD_DONE);

endmodule : mips_muldiv
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_muldiv
// Description : Directed self-checking bench for mips_muldiv. Expected values
//               are hand-computed constants. Honours MULDIV_FAST_MULT_EN for
//               multiply latency expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Edges after the accepting edge until done is seen
    function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) return 0;
`endif
        return W;
    endfunction

    // Bounded wait for done, sampling 1ns after each rising edge
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done && n < 200) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic mt,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int nbusy;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; mthi = mt;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        if (mt) check({tag, "/mthi_same_edge"}, hi, av);
        wait_done(n, nbusy);
        check({tag, "/latency"},     n,     exp_lat(o));
        check({tag, "/busy_cycles"}, nbusy, exp_lat(o));
        check({tag, "/busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "/hi"}, hi, ehi);
        check({tag, "/lo"}, lo, elo);
    endtask

    initial begin
        int n;
        int nbusy;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset/hi",   hi, 32'h0);
        check("reset/lo",   lo, 32'h0);
        check("reset/busy", {31'b0, busy}, 32'd0);
        check("reset/done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors (run back-to-back: each new start lands in the DONE cycle)
        run_op("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_minmin", OP_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);
        run_op("div_neg",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negdiv",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_7_2",    OP_DIVU,  32'h00000007, 32'h00000002, 1'b0, 32'h00000001, 32'h00000003);
        run_op("div_by0",     OP_DIV,   32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_by0_neg", OP_DIV,   32'hFFFFFFF9, 32'h00000000, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("divu_by0",    OP_DIVU,  32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_op("div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
        run_op("divu_mthi",   OP_DIVU,  32'h0000002A, 32'h00000006, 1'b1, 32'h00000000, 32'h00000007);

        @(posedge clk); #1;
        check("idle/done_pulse", {31'b0, done}, 32'd0);
        check("idle/busy",       {31'b0, busy}, 32'd0);

        // Moves while idle
        @(negedge clk); a = 32'hDEADBEEF; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0;
        check("mthi/hi", hi, 32'hDEADBEEF);
        check("mthi/lo", lo, 32'h00000007);
        @(negedge clk); a = 32'hCAFEF00D; mtlo = 1'b1;
        @(posedge clk); #1; mtlo = 1'b0;
        check("mtlo/lo", lo, 32'hCAFEF00D);
        check("mtlo/hi", hi, 32'hDEADBEEF);
        @(negedge clk); a = 32'h01234567; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        check("mtboth/hi", hi, 32'h01234567);
        check("mtboth/lo", lo, 32'h01234567);

        // start and mthi during busy are ignored
        @(negedge clk); start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3; mthi = 1'b1;
        @(posedge clk); #1; start = 1'b0; mthi = 1'b0; a = 32'hAA;
        check("busy_ign/hi_held", hi, 32'h01234567);
        check("busy_ign/busy",    {31'b0, busy}, 32'd1);
        wait_done(n, nbusy);
        check("busy_ign/latency", n + 5, 32'd32);
        check("busy_ign/lo", lo, 32'd14);
        check("busy_ign/hi", hi, 32'd2);

        // Asynchronous reset mid-operation
        @(negedge clk); start = 1'b1; op = OP_DIVU; a = 32'hFFFFFFFF; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midop/busy", {31'b0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst/busy", {31'b0, busy}, 32'd0);
        check("async_rst/done", {31'b0, done}, 32'd0);
        check("async_rst/hi",   hi, 32'h0);
        check("async_rst/lo",   lo, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Recovery after reset
        run_op("multu_6_7", OP_MULTU, 32'd6,  32'd7, 1'b0, 32'h0, 32'h2A);
        run_op("divu_42_6", OP_DIVU,  32'd42, 32'd6, 1'b0, 32'h0, 32'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mips_muldiv
`default_nettype wire
